// File: rtl/render_sequencer_if.sv
// Line-render handshake and shared VRAM fetch-port bundle between the render
// sequencer (master) and the composer / layer renderers (slave).
interface render_sequencer_if;
  logic       line_render_start;
  logic [8:0] line_idx;
  logic       layer0_enabled;
  logic       layer1_enabled;
  logic       sprites_enabled;
  logic       l0_done;
  logic       l1_done;
  logic       spr_done;
  logic [2:0] bus_req;
  logic [2:0] bus_gnt;
  logic       l0_start;
  logic       l1_start;
  logic       spr_start;
  logic       render_abort;
  logic [8:0] render_line_idx;
  logic       lb_wr_bank;
  logic       render_busy;
  logic       line_done;
  logic       render_overrun;
  logic       render_timeout;

  modport master (
    input  line_render_start, line_idx, layer0_enabled, layer1_enabled,
           sprites_enabled, l0_done, l1_done, spr_done, bus_req,
    output bus_gnt, l0_start, l1_start, spr_start, render_abort,
           render_line_idx, lb_wr_bank, render_busy, line_done,
           render_overrun, render_timeout
  );

  modport slave (
    output line_render_start, line_idx, layer0_enabled, layer1_enabled,
           sprites_enabled, l0_done, l1_done, spr_done, bus_req,
    input  bus_gnt, l0_start, l1_start, spr_start, render_abort,
           render_line_idx, lb_wr_bank, render_busy, line_done,
           render_overrun, render_timeout
  );
endinterface

// File: rtl/render_sequencer.sv
// Per-line render scheduler: start pulses, bank flip, round-robin VRAM port
// arbitration, completion/watchdog/overrun detection. Optional RENDER_STATS_EN.
module render_sequencer #(
  parameter int unsigned WATCHDOG_CYCLES = 800
) (
  input  logic               clk,
  input  logic               rst,
  render_sequencer_if.master bus
`ifdef RENDER_STATS_EN
  ,
  input  logic               stats_clear,
  output logic [7:0]         overrun_count,
  output logic [7:0]         timeout_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  localparam logic [10:0] WD_LOAD = 11'(WATCHDOG_CYCLES - 1);

  state_e      state_q, state_d;
  logic [8:0]  line_idx_q, line_idx_d;
  logic        bank_q, bank_d;
  logic [2:0]  en_q, en_d;       // {spr, l1, l0}, frozen for the whole line
  logic [2:0]  done_q, done_d;
  logic [10:0] wd_q, wd_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [1:0]  last_q, last_d;

  logic [2:0]  done_in, done_now, req_ok;
  logic        overrun, complete, timeout;
  logic [1:0]  cand, pick;
  logic        pick_vld;

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    done_in  = {bus.spr_done, bus.l1_done, bus.l0_done};
    done_now = done_q | (done_in & en_q);
    req_ok   = bus.bus_req & en_q;
    overrun  = bus.line_render_start && (state_q != S_IDLE);
    complete = (state_q == S_RUN) && !overrun && (&done_now);
    timeout  = (state_q == S_RUN) && !overrun && !(&done_now) && (wd_q == '0);

    state_d    = state_q;
    line_idx_d = line_idx_q;
    bank_d     = bank_q;
    en_d       = en_q;
    done_d     = done_q;
    wd_d       = wd_q;

    // A start in any state is accepted; in START/RUN it also aborts the line.
    if (bus.line_render_start) begin
      state_d    = S_START;
      line_idx_d = bus.line_idx;
      bank_d     = ~bank_q;
      en_d       = {bus.sprites_enabled, bus.layer1_enabled, bus.layer0_enabled};
      done_d     = '0;
    end else begin
      case (state_q)
        S_START: begin
          state_d = S_RUN;
          done_d  = ~en_q;
          wd_d    = WD_LOAD;
        end
        S_RUN: begin
          done_d = done_now;
          if (complete || timeout) state_d = S_IDLE;
          else                     wd_d    = wd_q - 11'd1;
        end
        default: ;
      endcase
    end

    // Nearest requester after the last owner wins; scan far-to-near.
    pick_vld = 1'b0;
    pick     = 2'd0;
    cand     = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      cand = 2'((int'(last_q) + k) % 3);
      if (req_ok[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end

    gnt_d  = '0;
    last_d = last_q;
    if (state_q == S_RUN && state_d == S_RUN) begin
      if (|(gnt_q & req_ok)) begin
        gnt_d = gnt_q;
      end else if (pick_vld) begin
        gnt_d  = 3'b001 << pick;
        last_d = pick;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      line_idx_q <= '0;
      bank_q     <= 1'b0;
      en_q       <= '0;
      done_q     <= '0;
      wd_q       <= '0;
      gnt_q      <= '0;
      last_q     <= 2'd2;
    end else begin
      state_q    <= state_d;
      line_idx_q <= line_idx_d;
      bank_q     <= bank_d;
      en_q       <= en_d;
      done_q     <= done_d;
      wd_q       <= wd_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
    end
  end

  assign bus.l0_start        = (state_q == S_START) && en_q[0];
  assign bus.l1_start        = (state_q == S_START) && en_q[1];
  assign bus.spr_start       = (state_q == S_START) && en_q[2];
  assign bus.render_busy     = (state_q != S_IDLE);
  assign bus.line_done       = complete || timeout;
  assign bus.render_abort    = overrun || timeout;
  assign bus.render_overrun  = overrun;
  assign bus.render_timeout  = timeout;
  assign bus.bus_gnt         = (overrun || timeout) ? 3'b000 : gnt_q;
  assign bus.render_line_idx = line_idx_q;
  assign bus.lb_wr_bank      = bank_q;

`ifdef RENDER_STATS_EN
  logic [7:0] ovr_cnt_q, ovr_cnt_d, to_cnt_q, to_cnt_d;

  always_comb begin
    ovr_cnt_d = ovr_cnt_q;
    to_cnt_d  = to_cnt_q;
    if (stats_clear) begin
      ovr_cnt_d = '0;
      to_cnt_d  = '0;
    end else begin
      if (overrun && ovr_cnt_q != 8'hff) ovr_cnt_d = ovr_cnt_q + 8'd1;
      if (timeout && to_cnt_q  != 8'hff) to_cnt_d  = to_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      ovr_cnt_q <= ovr_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign overrun_count = ovr_cnt_q;
  assign timeout_count = to_cnt_q;
`endif

endmodule
